apb_cmd_master: RTL and testbench

Parametrised APB4 master that replaces the fixed-code NOP/READ/WRITE request with a queued command interface. Each command carries address, write data, byte strobes and direction. Commands are buffered in an internal FIFO and issued one at a time as APB transfers. Each completed transfer returns one response carrying read data, slave error and timeout status. The block sits between a local requester and an APB slave fabric.

---
 rtl/apb_cmd_master.sv | 176 +++++++++++++++++
 tb/tb_apb_cmd_master.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// APB4 master fed by a command FIFO; issues one transfer at a time and returns
// one response (read data, slave error, timeout) per popped command.
module apb_cmd_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_write_i,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [DATA_W-1:0]   cmd_wdata_i,
    input  logic [DATA_W/8-1:0] cmd_strb_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                rsp_timeout_o,
    output logic                busy_o,
    output logic                psel_o,
    output logic                penable_o,
    output logic [ADDR_W-1:0]   paddr_o,
    output logic                pwrite_o,
    output logic [DATA_W-1:0]   pwdata_o,
    output logic [DATA_W/8-1:0] pstrb_o,
    input  logic [DATA_W-1:0]   prdata_i,
    input  logic                pready_i,
    input  logic                pslverr_i
);
    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    cmd_t              mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              cmd_ready_q, cmd_ready_d;
    state_t            state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [STRB_W-1:0] pstrb_q, pstrb_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              push, pop;
    cmd_t              head;

    assign head = mem_q[rd_ptr_q];
    assign push = cmd_valid_i && cmd_ready_o;

    // FIFO bookkeeping; ready is registered from the next count, so a pop
    // while full only reopens the input on the following cycle.
    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        cmd_ready_d = (count_d != CNT_W'(DEPTH));
    end

    always_comb begin
        state_d       = state_q;
        to_cnt_d      = '0;
        pop           = 1'b0;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = rsp_valid_q && !rsp_ready_i;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            IDLE: begin
                // Only issue when the response slot will be free to take the result.
                if ((count_q != '0) && (!rsp_valid_q || rsp_ready_i)) begin
                    pop      = 1'b1;
                    pwrite_d = head.write;
                    paddr_d  = head.addr;
                    pwdata_d = head.wdata;
                    pstrb_d  = head.write ? head.strb : '0;
                    state_d  = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (pready_i) begin
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata_i;
                    rsp_err_d     = pslverr_i;
                    rsp_timeout_d = 1'b0;
                    state_d       = IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1))) begin
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{write: cmd_write_i, addr: cmd_addr_i,
                                 wdata: cmd_wdata_i, strb: cmd_strb_i};
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            cmd_ready_q   <= 1'b1;
            state_q       <= IDLE;
            to_cnt_q      <= '0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            cmd_ready_q   <= cmd_ready_d;
            state_q       <= state_d;
            to_cnt_q      <= to_cnt_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Ready is masked while reset is held so the requester never pushes into a flush.
    assign cmd_ready_o   = cmd_ready_q && !preset;
    assign psel_o        = (state_q != IDLE);
    assign penable_o     = (state_q == ACCESS);
    assign paddr_o       = paddr_q;
    assign pwrite_o      = pwrite_q;
    assign pwdata_o      = pwdata_q;
    assign pstrb_o       = pstrb_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign busy_o        = (state_q != IDLE) || (count_q != '0) || rsp_valid_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed and randomized commands against a
// queue-based reference model and a behavioural APB slave.
module tb_apb_cmd_master;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int DEPTH  = 4;
    localparam int TMO    = 16;

    logic              pclk, preset;
    logic              cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_wdata_i;
    logic [STRB_W-1:0] cmd_strb_i;
    logic              rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_timeout_o, busy_o;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              psel_o, penable_o, pwrite_o;
    logic [ADDR_W-1:0] paddr_o;
    logic [DATA_W-1:0] pwdata_o, prdata_i;
    logic [STRB_W-1:0] pstrb_o;
    logic              pready_i, pslverr_i;

    apb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o),
        .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o), .pwrite_o(pwrite_o),
        .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .prdata_i(prdata_i),
        .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct { bit wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; } apb_t;
    typedef struct { int wt; logic [31:0] rdata; bit err; } slv_t;
    typedef struct { logic [31:0] rdata; bit err; bit tmo; } rsp_t;
    typedef struct { apb_t c; int acc; bit stable; } obs_t;

    slv_t slv_q[$];
    apb_t exp_apb_q[$];
    rsp_t exp_rsp_q[$];
    int   exp_acc_q[$];
    obs_t obs_q[$];
    int   checks = 0;
    int   failures = 0;
    int   setup_cnt = 0;

    // Behavioural slave: answers each transfer after the wait states queued for it.
    slv_t cur;
    apb_t seen;
    int   acc_n;
    bit   in_xfer = 0;
    bit   stab;
    always @(negedge pclk) begin
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        prdata_i  = $urandom;
        if (preset) begin
            in_xfer = 0;
        end else begin
            if (in_xfer && !(psel_o && penable_o)) begin
                obs_q.push_back('{seen, acc_n, stab});
                in_xfer = 0;
            end
            if (psel_o && !penable_o) begin
                seen = '{pwrite_o, paddr_o, pwdata_o, pstrb_o};
                acc_n = 0; stab = 1; in_xfer = 1;
                setup_cnt++;
                if (slv_q.size() > 0) cur = slv_q.pop_front();
                else cur = '{0, 32'h0, 1'b0};
            end else if (psel_o && penable_o) begin
                acc_n++;
                if ({pwrite_o, paddr_o, pwdata_o, pstrb_o} !== {seen.wr, seen.addr, seen.wdata, seen.strb})
                    stab = 0;
                if (acc_n == cur.wt + 1) begin
                    pready_i = 1'b1; prdata_i = cur.rdata; pslverr_i = cur.err;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: what the spec says each command must produce.
    task automatic model_add(bit wr, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                             int wt, logic [31:0] rd, bit er);
        bit tmo;
        tmo = (wt >= TMO);
        slv_q.push_back('{wt, rd, er});
        exp_apb_q.push_back('{wr, a, d, wr ? s : 4'h0});
        exp_rsp_q.push_back('{(wr || tmo) ? 32'h0 : rd, tmo ? 1'b1 : er, tmo});
        exp_acc_q.push_back(tmo ? TMO : wt + 1);
    endtask

    task automatic push(bit wr, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                        int wt, logic [31:0] rd, bit er);
        int n = 0;
        cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = a; cmd_wdata_i = d; cmd_strb_i = s;
        while (!cmd_ready_o && n < 100) begin
            @(posedge pclk); @(negedge pclk); n++;
        end
        chk("push_ready_wait", 128'(n < 100), 128'(1));
        @(posedge pclk);
        model_add(wr, a, d, s, wt, rd, er);
        @(negedge pclk);
        cmd_valid_i = 1'b0;
    endtask

    task automatic take_rsp(string tag, int hold);
        int n = 0;
        rsp_t e; obs_t o; apb_t ea; int eacc;
        logic [33:0] snap;
        while (!rsp_valid_o && n < 400) begin
            @(posedge pclk); @(negedge pclk); n++;
        end
        chk($sformatf("%s.rsp_wait", tag), 128'(rsp_valid_o), 128'(1));
        #1;
        if (exp_rsp_q.size() == 0 || obs_q.size() == 0) begin
            checks++; failures++;
            $error("FAIL %s.model observed=rsp/obs_present expected=queued_expectation", tag);
        end else begin
            e = exp_rsp_q.pop_front(); ea = exp_apb_q.pop_front(); eacc = exp_acc_q.pop_front();
            o = obs_q.pop_front();
            chk($sformatf("%s.rdata", tag), 128'(rsp_rdata_o), 128'(e.rdata));
            chk($sformatf("%s.err", tag), 128'(rsp_err_o), 128'(e.err));
            chk($sformatf("%s.timeout", tag), 128'(rsp_timeout_o), 128'(e.tmo));
            chk($sformatf("%s.apb", tag), {o.c.wr, o.c.addr, o.c.wdata, o.c.strb},
                {ea.wr, ea.addr, ea.wdata, ea.strb});
            chk($sformatf("%s.access_cycles", tag), 128'(o.acc), 128'(eacc));
            chk($sformatf("%s.apb_stable", tag), 128'(o.stable), 128'(1));
        end
        snap = {rsp_rdata_o, rsp_err_o, rsp_timeout_o};
        repeat (hold) begin
            @(posedge pclk); @(negedge pclk);
            chk($sformatf("%s.rsp_hold", tag), {rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o},
                {1'b1, snap});
        end
        rsp_ready_i = 1'b1;
        @(posedge pclk); @(negedge pclk);
        rsp_ready_i = 1'b0;
        chk($sformatf("%s.rsp_clear", tag), 128'(rsp_valid_o), 128'(0));
    endtask

    initial begin
        int n;
        int base;
        int k;
        preset = 1'b1; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0;
        cmd_wdata_i = '0; cmd_strb_i = '0; rsp_ready_i = 1'b0;

        // Reset state while preset is held, then release.
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("rst.cmd_ready", 128'(cmd_ready_o), 128'(0));
        chk("rst.outputs", {psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o, rsp_valid_o,
                            rsp_rdata_o, rsp_err_o, rsp_timeout_o, busy_o}, 128'(0));
        preset = 1'b0;
        #1;
        chk("rst.ready_after_release", 128'(cmd_ready_o), 128'(1));
        @(negedge pclk);

        // Zero-wait read: pop at N+1, SETUP at N+2, ACCESS at N+3, response sampled at N+4.
        cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 32'h10;
        cmd_wdata_i = 32'h0; cmd_strb_i = 4'hF;
        model_add(1'b0, 32'h10, 32'h0, 4'hF, 0, 32'h1234_5678, 1'b0);
        @(posedge pclk);
        @(negedge pclk); cmd_valid_i = 1'b0;
        chk("t1.after_push", {psel_o, penable_o, rsp_valid_o}, 128'(3'b000));
        @(negedge pclk);
        chk("t1.setup", {psel_o, penable_o, rsp_valid_o}, 128'(3'b100));
        @(negedge pclk);
        chk("t1.access", {psel_o, penable_o, rsp_valid_o}, 128'(3'b110));
        @(negedge pclk);
        chk("t1.response", {psel_o, penable_o, rsp_valid_o}, 128'(3'b001));
        take_rsp("t1", 0);

        // Write with 3 wait states, read with slave error.
        push(1'b1, 32'h20, 32'hDEAD_BEEF, 4'b0011, 3, 32'h5555_5555, 1'b0);
        take_rsp("t2", 2);
        push(1'b0, 32'h30, 32'hA5A5_A5A5, 4'hF, 1, 32'hCAFE_F00D, 1'b1);
        take_rsp("t5", 1);

        // Timeout, followed by a normal transfer; then the completion-vs-timeout boundary.
        push(1'b0, 32'h40, 32'h0, 4'hF, 100, 32'h1111_1111, 1'b0);
        push(1'b1, 32'h44, 32'h7777_0000, 4'hC, 0, 32'h0, 1'b0);
        take_rsp("t4.abort", 0);
        take_rsp("t4.next", 0);
        push(1'b0, 32'h48, 32'h0, 4'hF, TMO - 1, 32'h0BAD_CAFE, 1'b0);
        take_rsp("t4.last_cycle_ready", 0);
        push(1'b0, 32'h4C, 32'h0, 4'hF, TMO, 32'h0BAD_CAFE, 1'b0);
        take_rsp("t4.one_late", 0);

        // Fill the FIFO with the response slot occupied.
        base = setup_cnt;
        for (int i = 0; i <= DEPTH; i++)
            push(i[0], 32'h100 + 32'(4 * i), $urandom, 4'($urandom), 0, $urandom, 1'b0);
        chk("t3.full_ready", 128'(cmd_ready_o), 128'(0));
        cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 32'hBAD0; cmd_strb_i = 4'hF;
        repeat (6) @(negedge pclk);
        cmd_valid_i = 1'b0;
        chk("t3.still_full", {cmd_ready_o, busy_o}, 128'(2'b01));
        chk("t3.one_transfer", 128'(setup_cnt - base), 128'(1));
        for (int i = 0; i <= DEPTH; i++) take_rsp($sformatf("t3.order%0d", i), i % 2);
        chk("t3.drained", {busy_o, cmd_ready_o}, 128'(2'b01));

        // Reset during ACCESS with two entries queued.
        push(1'b0, 32'h200, 32'h0, 4'hF, 30, 32'h0, 1'b0);
        push(1'b1, 32'h204, 32'h1, 4'hF, 0, 32'h0, 1'b0);
        push(1'b1, 32'h208, 32'h2, 4'hF, 0, 32'h0, 1'b0);
        n = 0;
        while (!(psel_o && penable_o) && n < 20) begin @(negedge pclk); n++; end
        chk("t6.in_access", 128'(psel_o && penable_o), 128'(1));
        preset = 1'b1;
        slv_q.delete(); exp_apb_q.delete(); exp_rsp_q.delete(); exp_acc_q.delete();
        @(posedge pclk); @(negedge pclk);
        chk("t6.reset_outputs", {psel_o, penable_o, rsp_valid_o, busy_o, cmd_ready_o}, 128'(0));
        preset = 1'b0;
        #1;
        chk("t6.ready_after_release", 128'(cmd_ready_o), 128'(1));
        obs_q.delete();
        base = setup_cnt;
        repeat (12) @(negedge pclk);
        chk("t6.no_activity", {128'(setup_cnt - base), rsp_valid_o, busy_o}, 128'(0));

        // Randomized batches.
        for (int b = 0; b < 8; b++) begin
            k = $urandom_range(1, 3);
            for (int j = 0; j < k; j++)
                push(1'($urandom), $urandom, $urandom, 4'($urandom),
                     ($urandom_range(0, 7) == 0) ? TMO + 1 : $urandom_range(0, 3),
                     $urandom, ($urandom_range(0, 3) == 0));
            for (int j = 0; j < k; j++)
                take_rsp($sformatf("rnd%0d_%0d", b, j), $urandom_range(0, 2));
        end
        chk("end.idle", {busy_o, 128'(exp_rsp_q.size())}, 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
